// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg
// Shared definitions for the load/store unit and its byte-lane helper:
// access-size encodings, FSM state encoding, the word-alignment mask and a
// helper that classifies an access as illegal (misaligned or reserved size).
// No ports; imported by load_store_unit and lsu_byte_lane.

package load_store_unit_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    // Clears the byte offset so the memory always sees a word address.
    localparam logic [31:0] MEM_WORD_ALIGN = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } lsu_state_e;

    // An access is illegal when a halfword is on an odd byte, a word is not
    // on a word boundary, or the reserved size code is used.
    function automatic logic access_invalid(input logic [1:0] size,
                                            input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = (offset != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane
// Combinational byte-lane logic for the load/store unit, big-endian lane
// numbering (byte offset 0 is bits [31:24], halfword offset 0 is [31:16]).
// Ports:
//   word_i        word fetched from memory
//   offset_i      byte offset within the word (address bits [1:0])
//   size_i        access size (SIZE_BYTE / SIZE_HALF / SIZE_WORD)
//   is_unsigned_i 1 = zero-extend loads, 0 = sign-extend
//   new_data_i    right-justified store data
//   load_data_o   selected lane, extended to 32 bits
//   store_word_o  word_i with the addressed lane replaced by new_data_i

module lsu_byte_lane
    import load_store_unit_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        is_unsigned_i,
    input  logic [31:0] new_data_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        case (offset_i)
            2'd0:    lane_byte = word_i[31:24];
            2'd1:    lane_byte = word_i[23:16];
            2'd2:    lane_byte = word_i[15:8];
            default: lane_byte = word_i[7:0];
        endcase
        lane_half = offset_i[1] ? word_i[15:0] : word_i[31:16];

        case (size_i)
            SIZE_BYTE: load_data_o = is_unsigned_i ? {24'h0, lane_byte}
                                                   : {{24{lane_byte[7]}}, lane_byte};
            SIZE_HALF: load_data_o = is_unsigned_i ? {16'h0, lane_half}
                                                   : {{16{lane_half[15]}}, lane_half};
            default:   load_data_o = word_i;
        endcase
    end

    // Read-modify-write merge: only the addressed lane takes new data.
    always_comb begin
        store_word_o = word_i;
        case (size_i)
            SIZE_BYTE: begin
                case (offset_i)
                    2'd0:    store_word_o[31:24] = new_data_i[7:0];
                    2'd1:    store_word_o[23:16] = new_data_i[7:0];
                    2'd2:    store_word_o[15:8]  = new_data_i[7:0];
                    default: store_word_o[7:0]   = new_data_i[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (offset_i[1]) store_word_o[15:0]  = new_data_i[15:0];
                else             store_word_o[31:16] = new_data_i[15:0];
            end
            default: store_word_o = new_data_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
// Sequential load/store controller between the datapath and a word-wide data
// memory. Executes lb/lbu/lh/lhu/lw/sb/sh/sw; sub-word stores are done as a
// read followed by a merged whole-word write. All outputs are registered.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   in_Req                request strobe, only honoured in IDLE
//   in_Write/in_Size/in_Unsigned/in_Address_dw/in_WriteData_dw  request fields
//   in_MemReadData_dw     combinational read data from memory
//   o_MemAddress_dw       word-aligned memory address
//   o_MemWriteData_dw     word written to memory
//   o_MemRead/o_MemWrite  memory strobes
//   o_ReadData_dw         extended load result (updates only on good loads)
//   o_Busy                high whenever not IDLE
//   o_Done/o_Error        one-cycle completion pulse and its error flag

module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_Req,
    input  logic                  in_Write,
    input  logic [1:0]            in_Size,
    input  logic                  in_Unsigned,
    input  logic [31:0]           in_Address_dw,
    input  logic [DATA_WIDTH-1:0] in_WriteData_dw,
    input  logic [DATA_WIDTH-1:0] in_MemReadData_dw,
    output logic [31:0]           o_MemAddress_dw,
    output logic [DATA_WIDTH-1:0] o_MemWriteData_dw,
    output logic                  o_MemRead,
    output logic                  o_MemWrite,
    output logic [DATA_WIDTH-1:0] o_ReadData_dw,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic                  o_Error
);

    lsu_state_e            state_q,     state_d;
    logic                  write_q,     write_d;
    logic [1:0]            size_q,      size_d;
    logic                  unsigned_q,  unsigned_d;
    logic [1:0]            offset_q,    offset_d;
    logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
    logic [31:0]           mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_read_q,  mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [DATA_WIDTH-1:0] rdata_q,     rdata_d;
    logic                  done_q,      done_d;
    logic                  error_q,     error_d;

    logic [31:0] lane_load;
    logic [31:0] lane_store;

    lsu_byte_lane u_byte_lane (
        .word_i        (in_MemReadData_dw),
        .offset_i      (offset_q),
        .size_i        (size_q),
        .is_unsigned_i (unsigned_q),
        .new_data_i    (wdata_q),
        .load_data_o   (lane_load),
        .store_word_o  (lane_store)
    );

    // Next-state and next-output logic. Strobes, done and error are computed
    // for the state being entered so that they appear registered in it.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        offset_d    = offset_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        done_d      = 1'b0;
        error_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_Req) begin
                    write_d    = in_Write;
                    size_d     = in_Size;
                    unsigned_d = in_Unsigned;
                    offset_d   = in_Address_dw[1:0];
                    wdata_d    = in_WriteData_dw;
                    if (access_invalid(in_Size, in_Address_dw[1:0])) begin
                        // Illegal access: finish immediately, memory untouched.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        mem_addr_d = in_Address_dw & MEM_WORD_ALIGN;
                        if (in_Write && (in_Size == SIZE_WORD)) begin
                            state_d     = ST_WRITE;
                            mem_write_d = 1'b1;
                            mem_wdata_d = in_WriteData_dw;
                        end else begin
                            state_d    = ST_READ;
                            mem_read_d = 1'b1;
                        end
                    end
                end
            end
            ST_READ: begin
                if (write_q) begin
                    // Sub-word store: capture the merged word for the write.
                    mem_wdata_d = lane_store;
                    mem_write_d = 1'b1;
                    state_d     = ST_WRITE;
                end else begin
                    rdata_d = lane_load;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WRITE: begin
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            size_q      <= SIZE_BYTE;
            unsigned_q  <= 1'b0;
            offset_q    <= 2'b00;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            offset_q    <= offset_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign o_MemAddress_dw   = mem_addr_q;
    assign o_MemWriteData_dw = mem_wdata_q;
    assign o_MemRead         = mem_read_q;
    assign o_MemWrite        = mem_write_q;
    assign o_ReadData_dw     = rdata_q;
    assign o_Busy            = (state_q != ST_IDLE);
    assign o_Done            = done_q;
    assign o_Error           = error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Self-checking bench for load_store_unit. A 16-word memory model answers the
// DUT's strobes; a separate reference image of memory plus arithmetic lane
// rules gives the expected load results, stored words and cycle timing.

module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        in_Req;
    logic        in_Write;
    logic [1:0]  in_Size;
    logic        in_Unsigned;
    logic [31:0] in_Address_dw;
    logic [31:0] in_WriteData_dw;
    logic [31:0] in_MemReadData_dw;
    logic [31:0] o_MemAddress_dw;
    logic [31:0] o_MemWriteData_dw;
    logic        o_MemRead;
    logic        o_MemWrite;
    logic [31:0] o_ReadData_dw;
    logic        o_Busy;
    logic        o_Done;
    logic        o_Error;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] mem     [0:15];
    logic [31:0] ref_mem [0:15];
    bit          mem_ready = 1'b0;
    int          write_events = 0;
    logic [31:0] exp_rdata;

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_Req            (in_Req),
        .in_Write          (in_Write),
        .in_Size           (in_Size),
        .in_Unsigned       (in_Unsigned),
        .in_Address_dw     (in_Address_dw),
        .in_WriteData_dw   (in_WriteData_dw),
        .in_MemReadData_dw (in_MemReadData_dw),
        .o_MemAddress_dw   (o_MemAddress_dw),
        .o_MemWriteData_dw (o_MemWriteData_dw),
        .o_MemRead         (o_MemRead),
        .o_MemWrite        (o_MemWrite),
        .o_ReadData_dw     (o_ReadData_dw),
        .o_Busy            (o_Busy),
        .o_Done            (o_Done),
        .o_Error           (o_Error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] t;
        t = 32'h9E37_79B9 * 32'(i + 1);
        return (i == 4) ? 32'h8122_F344 : t;
    endfunction

    // Memory model: preloads while not ready, then writes on the same edge
    // that sees MemWrite high. Reads are combinational.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
        end else if (o_MemWrite) begin
            mem[o_MemAddress_dw[5:2]] <= o_MemWriteData_dw;
            write_events <= write_events + 1;
        end
    end

    assign in_MemReadData_dw = mem[o_MemAddress_dw[5:2]];

    // Reference rules: big-endian lanes, byte k sits 8*(3-k) bits up.
    function automatic bit ref_error(input logic [1:0] sz, input int a);
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] sz,
                                             input logic uns, input int off);
        int sh;
        logic [31:0] v;
        if (sz == 2'd0) begin
            sh = 8 * (3 - off);
            v  = (word >> sh) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            sh = 16 * (1 - off / 2);
            v  = (word >> sh) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [31:0] wd,
                                              input logic [1:0] sz, input int off);
        int sh;
        logic [31:0] mask;
        if (sz == 2'd0) begin
            sh   = 8 * (3 - off);
            mask = 32'hFF << sh;
        end else begin
            sh   = 16 * (1 - off / 2);
            mask = 32'hFFFF << sh;
        end
        return (word & ~mask) | ((wd << sh) & mask);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " addr"},   o_MemAddress_dw, 32'h0);
        checkOutput({tag, " wdata"},  o_MemWriteData_dw, 32'h0);
        checkOutput({tag, " rdata"},  o_ReadData_dw, 32'h0);
        checkOutput({tag, " strobes"}, {28'h0, o_MemRead, o_MemWrite, o_Busy, o_Done}, 32'h0);
        checkOutput({tag, " error"},  32'(o_Error), 32'h0);
    endtask

    // One complete transaction: issue, watch each cycle, compare with the
    // reference model, and confirm the unit goes quiet afterwards.
    task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input bit pulse_req, input string tag);
        bit          err;
        int          idx, off;
        logic [31:0] old_word, new_word;
        int          exp_done, exp_reads, exp_writes;
        int          done_cyc, reads, writes, read_cyc, write_cyc, extra, not_busy;
        logic        err_seen;
        logic [31:0] r_addr, w_addr, w_data;

        done_cyc = 0; reads = 0; writes = 0; read_cyc = 0; write_cyc = 0;
        extra = 0; not_busy = 0; err_seen = 1'b0;
        r_addr = 32'h0; w_addr = 32'h0; w_data = 32'h0;

        off      = int'(addr[1:0]);
        idx      = int'(addr[5:2]);
        err      = ref_error(sz, int'(addr));
        old_word = ref_mem[idx];
        new_word = old_word;
        if (err) begin
            exp_done = 1; exp_reads = 0; exp_writes = 0;
        end else if (!wr) begin
            exp_done = 2; exp_reads = 1; exp_writes = 0;
            exp_rdata = ref_load(old_word, sz, uns, off);
        end else if (sz == 2'd2) begin
            exp_done = 2; exp_reads = 0; exp_writes = 1;
            new_word = wd;
        end else begin
            exp_done = 3; exp_reads = 1; exp_writes = 1;
            new_word = ref_store(old_word, wd, sz, off);
        end
        ref_mem[idx] = new_word;

        @(negedge clk);
        in_Write        = wr;
        in_Size         = sz;
        in_Unsigned     = uns;
        in_Address_dw   = addr;
        in_WriteData_dw = wd;
        in_Req          = 1'b1;
        @(posedge clk);
        #1 in_Req = 1'b0;

        for (int c = 1; c <= 8 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (!o_Busy) not_busy++;
            if (o_MemRead) begin
                reads++;
                if (read_cyc == 0) read_cyc = c;
                r_addr = o_MemAddress_dw;
            end
            if (o_MemWrite) begin
                writes++;
                if (write_cyc == 0) write_cyc = c;
                w_addr = o_MemAddress_dw;
                w_data = o_MemWriteData_dw;
            end
            if (o_Done) begin
                done_cyc = c;
                err_seen = o_Error;
            end
            if (pulse_req && c == 1) in_Req = 1'b1;
        end
        in_Req = 1'b0;

        repeat (2) begin
            @(negedge clk);
            if (o_Done || o_MemRead || o_MemWrite || o_Busy) extra++;
        end

        checkOutput({tag, " done cycle"}, 32'(done_cyc), 32'(exp_done));
        checkOutput({tag, " error"}, 32'(err_seen), 32'(err));
        checkOutput({tag, " reads"}, 32'(reads), 32'(exp_reads));
        checkOutput({tag, " writes"}, 32'(writes), 32'(exp_writes));
        if (exp_reads != 0) begin
            checkOutput({tag, " read cycle"}, 32'(read_cyc), 32'd1);
            checkOutput({tag, " read addr"}, r_addr, addr & 32'hFFFF_FFFC);
        end
        if (exp_writes != 0) begin
            checkOutput({tag, " write cycle"}, 32'(write_cyc), 32'(exp_done - 1));
            checkOutput({tag, " write addr"}, w_addr, addr & 32'hFFFF_FFFC);
            checkOutput({tag, " write data"}, w_data, new_word);
        end
        checkOutput({tag, " rdata"}, o_ReadData_dw, exp_rdata);
        checkOutput({tag, " mem word"}, mem[idx], ref_mem[idx]);
        checkOutput({tag, " busy gaps"}, 32'(not_busy), 32'd0);
        checkOutput({tag, " after done"}, 32'(extra), 32'd0);
    endtask

    initial begin
        logic        wr, uns;
        logic [1:0]  sz;
        logic [31:0] addr, wd;
        int          w0, rst_extra;

        reset = 1'b0;
        in_Req = 1'b0; in_Write = 1'b0; in_Size = 2'b00; in_Unsigned = 1'b0;
        in_Address_dw = 32'h0; in_WriteData_dw = 32'h0;
        exp_rdata = 32'h0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);

        repeat (3) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b1;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Loads on word 0x10 = 0x8122F344
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 1'b0, "lb 0x10");
        checkOutput("lb 0x10 value", o_ReadData_dw, 32'hFFFF_FF81);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 1'b0, "lbu 0x10");
        checkOutput("lbu 0x10 value", o_ReadData_dw, 32'h0000_0081);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b0, "lh 0x12");
        checkOutput("lh 0x12 value", o_ReadData_dw, 32'hFFFF_F344);
        applyStimulus(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0, "lhu 0x12");
        checkOutput("lhu 0x12 value", o_ReadData_dw, 32'h0000_F344);

        // Sub-word store then read back
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AB, 1'b0, "sb 0x11");
        checkOutput("sb 0x11 mem", mem[4], 32'h81AB_F344);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, "lw 0x10");
        checkOutput("lw 0x10 value", o_ReadData_dw, 32'h81AB_F344);

        // Word store, errors, and a request pulse while busy
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, "sw 0x10");
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 1'b0, "lh 0x11 misaligned");
        checkOutput("misaligned keeps rdata", o_ReadData_dw, 32'h81AB_F344);
        applyStimulus(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1'b0, "size 11");
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, "lw req pulse");
        checkOutput("lw req pulse value", o_ReadData_dw, 32'hDEAD_BEEF);

        // sh 0x12 aborted by reset before its write can happen
        @(negedge clk);
        in_Write = 1'b1; in_Size = 2'd1; in_Unsigned = 1'b0;
        in_Address_dw = 32'h12; in_WriteData_dw = 32'h0000_5A5A; in_Req = 1'b1;
        @(posedge clk);
        #1 in_Req = 1'b0;
        @(negedge clk);
        checkOutput("rst sh read phase", 32'(o_MemRead), 32'd1);
        w0 = write_events;
        reset = 1'b0;
        #1 checkAllZero("rst sh asserted");
        @(negedge clk);
        checkAllZero("rst sh held");
        reset = 1'b1;
        exp_rdata = 32'h0;
        rst_extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (o_MemWrite || o_MemRead || o_Busy || o_Done) rst_extra++;
        end
        checkOutput("rst sh quiet", 32'(rst_extra), 32'd0);
        checkOutput("rst sh no write", 32'(write_events), 32'(w0));
        checkOutput("rst sh mem", mem[4], ref_mem[4]);

        // Randomized traffic over the 16-word window
        for (int n = 0; n < 60; n++) begin
            wr   = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            uns  = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 63));
            wd   = $urandom;
            applyStimulus(wr, sz, uns, addr, wd, 1'($urandom_range(0, 1)),
                          $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequential load/store controller between the MIPS datapath and the word-wide data memory; it is the initiator that drives the memory's address, write-data, MemRead and MemWrite strobes. It executes lb/lbu/lh/lhu/lw/sb/sh/sw requests from the datapath. Sub-word stores are done as read-modify-write, because the data memory only writes whole words. It reports completion with a one-cycle done pulse and flags misaligned accesses without touching memory.

## Interface
- DATA_WIDTH, 32, datapath and memory word width (fixed 32 for byte-lane logic)
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- in_Req  input  1  request strobe, sampled only in IDLE
- in_Write  input  1  1 = store, 0 = load
- in_Size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (error)
- in_Unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
- in_Address_dw  input  32  byte address
- in_WriteData_dw  input  32  store data, right-justified for sub-word stores
- in_MemReadData_dw  input  32  combinational read data from data memory
- o_MemAddress_dw  output  32  word-aligned byte address to memory (bits [1:0] = 0)
- o_MemWriteData_dw  output  32  word to memory
- o_MemRead  output  1  memory read enable
- o_MemWrite  output  1  memory write enable (memory writes on the same rising edge)
- o_ReadData_dw  output  32  extended load result, registered
- o_Busy  output  1  high in every non-IDLE state
- o_Done  output  1  one-cycle completion pulse
- o_Error  output  1  misalignment / reserved size, valid with o_Done

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE + in_Req: latch write, size, unsigned, address and write data.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0) or size 11 → DONE with error.
  - Load → READ.
  - Word store → WRITE.
  - Byte/half store → READ.
- READ: o_MemRead=1 and o_MemAddress_dw={addr[31:2],2'b00}.
  - Load: extract the lane, extend it, register it into o_ReadData_dw, then go to DONE.
  - Sub-word store: register the fetched word, then go to WRITE.
- WRITE: o_MemWrite=1.
  - Data = latched word (sw), or the fetched word with the target lane replaced by in_WriteData_dw[7:0] or [15:0].
  - Then go to DONE.
- DONE: o_Done=1 and o_Error set as decided; next state is IDLE.
- Byte order is big-endian:
  - Offset 0 → bits [31:24], offset 3 → [7:0].
  - Half offset 0 → [31:16], offset 2 → [15:0].
- o_ReadData_dw updates only on a successful load. It holds its value through stores, errors and IDLE.
- in_Req outside IDLE is ignored. No queueing.
- Strobes are 0 in IDLE and DONE. Address and write-data outputs hold their last values.
- Errors assert no memory strobes. o_ReadData_dw is unchanged on an error.

## Timing
- Cycle 0 is the request-accept edge in IDLE.
- Load: READ in cycle 1, o_Done in cycle 2.
- sw: WRITE in cycle 1, o_Done in cycle 2.
- sb/sh: READ in cycle 1, WRITE in cycle 2, o_Done in cycle 3.
- Error: o_Done and o_Error in cycle 1.
- Earliest next accept is the cycle after DONE.
- Reset (asynchronous, any state, including between READ and WRITE):
  - State → IDLE.
  - All outputs → 0, including o_ReadData_dw and o_MemAddress_dw.
  - No pending write is issued after reset is released.

## Structure
- Shared header: size encodings (SIZE_BYTE/HALF/WORD), state encodings, MEM_WORD_ALIGN mask.
- Sub-module lsu_byte_lane (combinational):
  - Load extract/extend from (word, offset, size, unsigned).
  - Store merge from (old word, new data, offset, size).
- The top level holds the FSM and registers.

## Test plan
- Word 0x10 = 0x8122F344:
  - lb 0x10 → 0xFFFFFF81.
  - lbu 0x10 → 0x00000081.
  - lh 0x12 → 0xFFFFF344.
  - lhu 0x12 → 0x0000F344.
  - Each load: o_MemRead in cycle 1 only, o_Done in cycle 2.
- sb 0x11 with data 0x000000AB on word 0x8122F344:
  - READ cycle 1, then WRITE 0x81ABF344 at address 0x10 in cycle 2.
  - o_Done in cycle 3; a following lw 0x10 returns 0x81ABF344.
- sw 0x10 with 0xDEADBEEF:
  - o_MemWrite in cycle 1, o_MemRead never asserted, o_Done in cycle 2.
- lh 0x11 and in_Size=11:
  - o_Done and o_Error in cycle 1, no strobes.
  - o_ReadData_dw keeps its previous value.
- sh 0x12 with reset asserted after the READ cycle:
  - o_MemWrite never asserted, memory word unchanged.
  - All outputs 0 while reset is low.
- in_Req pulsed during READ of an active load:
  - Ignored; exactly one o_Done, one memory access.
